multiplier_arbiter: RTL

Shares one pipelined signed multiplier (sysDSP-inferred, fixed latency, no stall, no reset) among NUM_REQ requesters. Examples are the DCT and quantizer stages of the JPEG pipeline.
Each cycle it grants one requester round-robin and drives that requester's operands into the multiplier. It tracks the owner of each in-flight product in a tag pipeline and returns the product to that owner after a fixed latency.

---
 rtl/multiplier_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/multiplier_arbiter.sv
// Purpose  : shares one external pipelined signed multiplier among NUM_REQ
//            requesters using round-robin grants, and routes each product
//            back to the requester that issued it.
// Latency  : a transfer at edge t raises resp_valid for the cycle after edge
//            t+MUL_DEPTH. One product per cycle.
// Backpress: req_ready is a combinational one-hot grant. Responses cannot be
//            stalled, so a requester must take its result on the pulse.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   req_valid/req_a/req_b per-requester operands, packed [i*WIDTH +: WIDTH]
//   req_ready             one-hot grant, zero while reset is high
//   mul_a/mul_b, mul_p    operands to, and product from, the external multiplier
//   resp_valid/resp_data  one-hot owner pulse and the registered product
//   idle                  no product in flight and no response pulse
module multiplier_arbiter #(
   parameter int WIDTH     = 16,
   parameter int MUL_DEPTH = 2,
   parameter int NUM_REQ   = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [WIDTH-1:0]           mul_a,
   output logic [WIDTH-1:0]           mul_b,
   input  logic [2*WIDTH-1:0]         mul_p,
   output logic [NUM_REQ-1:0]         resp_valid,
   output logic [2*WIDTH-1:0]         resp_data,
   output logic                       idle
);

   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IDW-1:0]       rr_ptr;
   logic [IDW-1:0]       gnt_id;
   logic                 gnt_found;
   logic                 xfer;
   logic [WIDTH-1:0]     a_arr [NUM_REQ];
   logic [WIDTH-1:0]     b_arr [NUM_REQ];
   logic [MUL_DEPTH-1:0] tag_vld;
   logic [IDW-1:0]       tag_id [MUL_DEPTH];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
      assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
   end

   // Cyclic search starting at rr_ptr. rr_ptr + k is below 2*NUM_REQ, so a
   // single conditional subtract is enough to wrap the index.
   always_comb begin
      logic [IDW:0]   sum;
      logic [IDW-1:0] idx;
      gnt_found = 1'b0;
      gnt_id    = '0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr} + (IDW+1)'(k);
         if (sum >= (IDW+1)'(NUM_REQ)) begin
            sum = sum - (IDW+1)'(NUM_REQ);
         end
         idx = sum[IDW-1:0];
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_id    = idx;
         end
      end
   end

   // A grant always completes: ready is only raised on a valid requester.
   assign xfer = gnt_found & ~reset;

   always_comb begin
      req_ready = '0;
      mul_a     = '0;
      mul_b     = '0;
      if (xfer) begin
         req_ready = NUM_REQ'(1) << gnt_id;
         mul_a     = a_arr[gnt_id];
         mul_b     = b_arr[gnt_id];
      end
   end

   // Moving past the winner gives the next requester priority; a lone
   // requester is still found again by the cyclic search.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (xfer) begin
         rr_ptr <= (gnt_id == IDW'(NUM_REQ-1)) ? '0 : gnt_id + IDW'(1);
      end
   end

   // Owner tags travel alongside the multiplier pipeline; the last stage
   // lines up with mul_p. The multiplier itself has no reset, so clearing
   // the valid bits is what discards its in-flight products.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_vld <= '0;
         for (int k = 0; k < MUL_DEPTH; k++) begin
            tag_id[k] <= '0;
         end
      end else begin
         tag_vld[0] <= xfer;
         tag_id[0]  <= gnt_id;
         for (int k = 1; k < MUL_DEPTH; k++) begin
            tag_vld[k] <= tag_vld[k-1];
            tag_id[k]  <= tag_id[k-1];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_valid <= '0;
         resp_data  <= '0;
      end else if (tag_vld[MUL_DEPTH-1]) begin
         resp_valid <= NUM_REQ'(1) << tag_id[MUL_DEPTH-1];
         resp_data  <= mul_p;
      end else begin
         resp_valid <= '0;
      end
   end

   assign idle = ~|tag_vld & ~|resp_valid;

endmodule
